dlk_region_monitor: RTL and testbench

- Parametrised successor to the single-channel data-leak buffer.
- Tracks up to NUM_REGIONS byte-store-built buffers. Each region is keyed by the base register value and records the highest byte written so far.
- Flags any load, through a tracked base, that reads outside `[base, limit)`. Violations are registered.
- Sits beside the branch unit in EX, fed from `fu_data_i`. `violation_o` feeds the crash/redirect path gated by `en_crash_i`.

---
 rtl/dlk_pkg.sv | 33 +++
 rtl/dlk_region_match.sv | 27 ++
 rtl/dlk_region_monitor.sv | 182 ++++++++++++++++++
 tb/tb_dlk_region_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dlk_pkg.sv
// Shared types for the data-leak region monitor. The age field exists only
// when DLK_MONITOR_LRU_EN is defined.
package dlk_pkg;

   localparam int DLK_ADDR_W = 32;
   localparam int DLK_AGE_W  = 4;

   typedef enum logic [1:0] {
      DLK_B    = 2'd0,
      DLK_H    = 2'd1,
      DLK_W    = 2'd2,
      DLK_RSVD = 2'd3
   } dlk_size_e;

   typedef struct packed {
      logic                  valid;
      logic [DLK_ADDR_W-1:0] base;
      logic [DLK_ADDR_W:0]   limit;
`ifdef DLK_MONITOR_LRU_EN
      logic [DLK_AGE_W-1:0]  age;
`endif
   } dlk_region_t;

   function automatic logic [2:0] access_bytes(input dlk_size_e size);
      case (size)
         DLK_B:   access_bytes = 3'd1;
         DLK_H:   access_bytes = 3'd2;
         DLK_W:   access_bytes = 3'd4;
         default: access_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/dlk_region_match.sv
// Lowest-index base lookup over the region table; combinational, zero latency.
// No flow control: hit/idx follow the inputs in the same cycle.
module dlk_region_match #(
   parameter int NUM_REGIONS = 8,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic [NUM_REGIONS-1:0]                 valid,
   input  logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] base,
   input  logic [ADDR_WIDTH-1:0]                  key,
   output logic                                   hit,
   output logic [$clog2(NUM_REGIONS)-1:0]         idx
);

   localparam int IW = $clog2(NUM_REGIONS);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (valid[i] && (base[i] == key)) begin
            hit = 1'b1;
            idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/dlk_region_monitor.sv
// Tracks store-built buffers and flags loads outside [base, limit); 1-cycle registered violation.
// Never stalls the pipe. DLK_MONITOR_LRU_EN selects LRU instead of round-robin replacement.
module dlk_region_monitor
   import dlk_pkg::*;
#(
   parameter int NUM_REGIONS = 8,
   parameter int ADDR_WIDTH  = DLK_ADDR_W,
   parameter int MAX_REGION  = 4096,
   parameter int AGE_WIDTH   = DLK_AGE_W
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           en_i,
   input  logic                           clear_i,
   input  logic                           st_valid_i,
   input  logic [ADDR_WIDTH-1:0]          st_base_i,
   input  logic [ADDR_WIDTH-1:0]          st_addr_i,
   input  logic [1:0]                     st_size_i,
   input  logic                           ld_valid_i,
   input  logic [ADDR_WIDTH-1:0]          ld_base_i,
   input  logic [ADDR_WIDTH-1:0]          ld_addr_i,
   input  logic [1:0]                     ld_size_i,
   output logic                           violation_o,
   output logic [ADDR_WIDTH-1:0]          violation_addr_o,
   output logic                           sticky_o,
   output logic [$clog2(NUM_REGIONS):0]   occupancy_o,
   input  logic [$clog2(NUM_REGIONS)-1:0] dbg_idx_i,
   output logic [ADDR_WIDTH-1:0]          dbg_base_o,
   output logic [ADDR_WIDTH-1:0]          dbg_limit_o
);

   localparam int IW = $clog2(NUM_REGIONS);
   localparam logic [ADDR_WIDTH:0] MAX_SPAN = (ADDR_WIDTH + 1)'(MAX_REGION);

   // The entry struct lives in the package, so its widths are fixed there.
   if ((ADDR_WIDTH != DLK_ADDR_W) || (AGE_WIDTH != DLK_AGE_W)) begin : g_cfg_check
      $error("dlk_region_monitor: ADDR_WIDTH/AGE_WIDTH must match dlk_pkg");
   end

   dlk_region_t regions_q [NUM_REGIONS];
   dlk_region_t regions_d [NUM_REGIONS];

   logic [NUM_REGIONS-1:0]                 valid_vec;
   logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] base_vec;
   logic                st_hit, ld_hit, free_vld;
   logic [IW-1:0]       st_idx, ld_idx, free_idx, victim_idx, alloc_idx;
   logic                st_act, ld_act, st_grow, alloc, ld_viol;
   logic [ADDR_WIDTH:0] st_end, ld_end;
   logic [IW:0]         occ_q, occ_d;
   logic                viol_q, sticky_q;
   logic [ADDR_WIDTH-1:0] viol_addr_q;

   always_comb begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
         valid_vec[i] = regions_q[i].valid;
         base_vec[i]  = regions_q[i].base;
      end
   end

   dlk_region_match #(.NUM_REGIONS(NUM_REGIONS), .ADDR_WIDTH(ADDR_WIDTH)) u_st_match (
      .valid (valid_vec), .base (base_vec), .key (st_base_i), .hit (st_hit), .idx (st_idx)
   );

   dlk_region_match #(.NUM_REGIONS(NUM_REGIONS), .ADDR_WIDTH(ADDR_WIDTH)) u_ld_match (
      .valid (valid_vec), .base (base_vec), .key (ld_base_i), .hit (ld_hit), .idx (ld_idx)
   );

   assign st_act = en_i & st_valid_i & (st_size_i != DLK_RSVD) & ~clear_i;
   assign ld_act = en_i & ld_valid_i & (ld_size_i != DLK_RSVD) & ~clear_i;
   assign st_end = {1'b0, st_addr_i} + (ADDR_WIDTH + 1)'(access_bytes(dlk_size_e'(st_size_i)));
   assign ld_end = {1'b0, ld_addr_i} + (ADDR_WIDTH + 1)'(access_bytes(dlk_size_e'(ld_size_i)));

   // Span check is only meaningful once addr >= base, so the subtraction cannot wrap.
   assign st_grow = st_act & st_hit & (st_addr_i >= regions_q[st_idx].base) &
                    ((st_end - {1'b0, regions_q[st_idx].base}) <= MAX_SPAN);
   assign alloc   = st_act & ~st_hit & (st_addr_i == st_base_i);
   assign ld_viol = ld_act & ld_hit & ((ld_addr_i < regions_q[ld_idx].base) |
                                       (ld_end > regions_q[ld_idx].limit));

   always_comb begin
      free_vld = 1'b0;
      free_idx = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (!regions_q[i].valid) begin
            free_vld = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   assign alloc_idx = free_vld ? free_idx : victim_idx;

`ifdef DLK_MONITOR_LRU_EN
   logic [NUM_REGIONS-1:0] touch;
   logic [AGE_WIDTH-1:0]   best_age;

   always_comb begin
      victim_idx = '0;
      best_age   = regions_q[0].age;
      for (int i = 1; i < NUM_REGIONS; i++) begin
         if (regions_q[i].age > best_age) begin
            best_age   = regions_q[i].age;
            victim_idx = IW'(i);
         end
      end
   end

   // Allocation counts as a touch so a fresh entry starts as most-recently used.
   always_comb begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
         touch[i] = (st_act & st_hit & (st_idx == IW'(i))) |
                    (ld_act & ld_hit & (ld_idx == IW'(i))) |
                    (alloc & (alloc_idx == IW'(i)));
      end
   end
`else
   logic [IW-1:0] rr_q;

   assign victim_idx = rr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
      end else if (clear_i) begin
         rr_q <= '0;
      end else if (alloc && !free_vld) begin
         rr_q <= rr_q + IW'(1);
      end
   end
`endif

   always_comb begin
      regions_d = regions_q;
      occ_d     = occ_q;
      if (clear_i) begin
         for (int i = 0; i < NUM_REGIONS; i++) regions_d[i].valid = 1'b0;
         occ_d = '0;
      end else begin
`ifdef DLK_MONITOR_LRU_EN
         if (|touch) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
               if (touch[i]) regions_d[i].age = '0;
               else if (regions_q[i].valid && (regions_q[i].age != '1))
                  regions_d[i].age = regions_q[i].age + AGE_WIDTH'(1);
            end
         end
`endif
         if (st_grow && (st_end > regions_q[st_idx].limit)) regions_d[st_idx].limit = st_end;
         if (alloc) begin
            regions_d[alloc_idx].valid = 1'b1;
            regions_d[alloc_idx].base  = st_base_i;
            regions_d[alloc_idx].limit = st_end;
            if (free_vld) occ_d = occ_q + (IW + 1)'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGIONS; i++) regions_q[i] <= '0;
         occ_q       <= '0;
         viol_q      <= 1'b0;
         viol_addr_q <= '0;
         sticky_q    <= 1'b0;
      end else begin
         regions_q <= regions_d;
         occ_q     <= occ_d;
         viol_q    <= ld_viol;
         if (ld_viol) viol_addr_q <= ld_addr_i;
         if (clear_i) sticky_q <= 1'b0;
         else if (ld_viol) sticky_q <= 1'b1;
      end
   end

   assign violation_o      = viol_q;
   assign violation_addr_o = viol_addr_q;
   assign sticky_o         = sticky_q;
   assign occupancy_o      = occ_q;
   assign dbg_base_o       = regions_q[dbg_idx_i].base;
   assign dbg_limit_o      = regions_q[dbg_idx_i].valid ? regions_q[dbg_idx_i].limit[ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_dlk_region_monitor.sv
// Directed vector table plus hand-written sequences for dlk_region_monitor.
module tb_dlk_region_monitor;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        en_i = 1'b0, clear_i = 1'b0, st_valid_i = 1'b0, ld_valid_i = 1'b0;
   logic [31:0] st_base_i = '0, st_addr_i = '0, ld_base_i = '0, ld_addr_i = '0;
   logic [1:0]  st_size_i = '0, ld_size_i = '0;
   logic        violation_o, sticky_o;
   logic [31:0] violation_addr_o, dbg_base_o, dbg_limit_o;
   logic [3:0]  occupancy_o;
   logic [2:0]  dbg_idx_i = '0;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic        clr, en, sv;
      logic [31:0] sb, sa;
      logic [1:0]  ss;
      logic        lv;
      logic [31:0] lb, la;
      logic [1:0]  ls;
      logic        ev;
      logic [31:0] eva;
      logic        est;
      logic [3:0]  eocc;
   } vec_t;

   vec_t vecs[$];

   dlk_region_monitor dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clear_i(clear_i),
      .st_valid_i(st_valid_i), .st_base_i(st_base_i), .st_addr_i(st_addr_i), .st_size_i(st_size_i),
      .ld_valid_i(ld_valid_i), .ld_base_i(ld_base_i), .ld_addr_i(ld_addr_i), .ld_size_i(ld_size_i),
      .violation_o(violation_o), .violation_addr_o(violation_addr_o), .sticky_o(sticky_o),
      .occupancy_o(occupancy_o), .dbg_idx_i(dbg_idx_i), .dbg_base_o(dbg_base_o), .dbg_limit_o(dbg_limit_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic clr, input logic en, input logic sv, input logic [31:0] sb,
                      input logic [31:0] sa, input logic [1:0] ss, input logic lv, input logic [31:0] lb,
                      input logic [31:0] la, input logic [1:0] ls, input logic ev, input logic [31:0] eva,
                      input logic est, input logic [3:0] eocc);
      vec_t v;
      v.clr = clr; v.en = en; v.sv = sv; v.sb = sb; v.sa = sa; v.ss = ss;
      v.lv = lv; v.lb = lb; v.la = la; v.ls = ls;
      v.ev = ev; v.eva = eva; v.est = est; v.eocc = eocc;
      vecs.push_back(v);
   endtask

   task automatic add_st(input logic [31:0] sb, input logic [31:0] sa, input logic [1:0] ss,
                         input logic ev, input logic [31:0] eva, input logic est, input logic [3:0] eocc);
      add(1'b0, 1'b1, 1'b1, sb, sa, ss, 1'b0, '0, '0, 2'd0, ev, eva, est, eocc);
   endtask

   task automatic add_ld(input logic [31:0] lb, input logic [31:0] la, input logic [1:0] ls,
                         input logic ev, input logic [31:0] eva, input logic est, input logic [3:0] eocc);
      add(1'b0, 1'b1, 1'b0, '0, '0, 2'd0, 1'b1, lb, la, ls, ev, eva, est, eocc);
   endtask

   task automatic drive(input vec_t v);
      clear_i = v.clr; en_i = v.en;
      st_valid_i = v.sv; st_base_i = v.sb; st_addr_i = v.sa; st_size_i = v.ss;
      ld_valid_i = v.lv; ld_base_i = v.lb; ld_addr_i = v.la; ld_size_i = v.ls;
   endtask

   task automatic idle();
      clear_i = 1'b0; en_i = 1'b1; st_valid_i = 1'b0; ld_valid_i = 1'b0;
   endtask

   task automatic chk_dbg(input logic [2:0] idx, input logic [31:0] eb, input logic [31:0] el);
      dbg_idx_i = idx;
      #1;
      chk($sformatf("dbg%0d.base", idx), dbg_base_o, eb);
      chk($sformatf("dbg%0d.limit", idx), dbg_limit_o, el);
   endtask

   initial begin
      // Buffer built byte by byte, then bounds checks at both edges.
      for (int i = 0; i < 16; i++) add_st(32'h1000, 32'h1000 + i, 2'd0, 0, 32'h0, 0, 4'd1);
      add_ld(32'h1000, 32'h100C, 2'd2, 0, 32'h0,    0, 4'd1);
      add_ld(32'h1000, 32'h100E, 2'd1, 0, 32'h0,    0, 4'd1);
      add_ld(32'h1000, 32'h1010, 2'd2, 1, 32'h1010, 1, 4'd1);
      add(0, 1, 0, '0, '0, 2'd0, 0, '0, '0, 2'd0, 0, 32'h1010, 1, 4'd1);
      add_ld(32'h1000, 32'h100F, 2'd1, 1, 32'h100F, 1, 4'd1);
      add_ld(32'h1000, 32'h0FFF, 2'd0, 1, 32'h0FFF, 1, 4'd1);
      add_ld(32'h1000, 32'h2000, 2'd3, 0, 32'h0FFF, 1, 4'd1);
      add_ld(32'h7000, 32'h9000, 2'd0, 0, 32'h0FFF, 1, 4'd1);
      // Same-cycle store/load sees the old limit.
      add(0, 1, 1, 32'h1000, 32'h1010, 2'd0, 1, 32'h1000, 32'h1010, 2'd0, 1, 32'h1010, 1, 4'd1);
      add_ld(32'h1000, 32'h1010, 2'd0, 0, 32'h1010, 1, 4'd1);
      // Stores below base or beyond MAX_REGION are ignored; exactly MAX_REGION is accepted.
      add_st(32'h1000, 32'h0FFF, 2'd0, 0, 32'h1010, 1, 4'd1);
      add_ld(32'h1000, 32'h0FFF, 2'd0, 1, 32'h0FFF, 1, 4'd1);
      add_st(32'h1000, 32'h2000, 2'd0, 0, 32'h0FFF, 1, 4'd1);
      add_ld(32'h1000, 32'h1FFF, 2'd0, 1, 32'h1FFF, 1, 4'd1);
      add_st(32'h1000, 32'h1FFF, 2'd0, 0, 32'h1FFF, 1, 4'd1);
      add_ld(32'h1000, 32'h1FFF, 2'd0, 0, 32'h1FFF, 1, 4'd1);
      add_ld(32'h1000, 32'h2000, 2'd0, 1, 32'h2000, 1, 4'd1);
      add_st(32'h5000, 32'h5004, 2'd0, 0, 32'h2000, 1, 4'd1);
      add_ld(32'h5000, 32'h6000, 2'd0, 0, 32'h2000, 1, 4'd1);
      // Disabled monitor: no allocation, no violation, sticky held.
      add(0, 0, 1, 32'h6000, 32'h6000, 2'd0, 0, '0, '0, 2'd0, 0, 32'h2000, 1, 4'd1);
      add(0, 0, 0, '0, '0, 2'd0, 1, 32'h1000, 32'h3000, 2'd0, 0, 32'h2000, 1, 4'd1);
      add_ld(32'h6000, 32'h7000, 2'd0, 0, 32'h2000, 1, 4'd1);
      // Clear wins over a simultaneous out-of-range load.
      add(1, 1, 0, '0, '0, 2'd0, 1, 32'h1000, 32'h3000, 2'd0, 0, 32'h2000, 0, 4'd0);
      add_ld(32'h1000, 32'h3000, 2'd0, 0, 32'h2000, 0, 4'd0);
      add_st(32'h4000, 32'h4000, 2'd2, 0, 32'h2000, 0, 4'd1);
      add_ld(32'h4000, 32'h4000, 2'd2, 0, 32'h2000, 0, 4'd1);
      add_ld(32'h4000, 32'h4004, 2'd0, 1, 32'h4004, 1, 4'd1);
      add(1, 1, 0, '0, '0, 2'd0, 0, '0, '0, 2'd0, 0, 32'h4004, 0, 4'd0);
      // Fill, touch entry 0, then force a replacement.
      for (int i = 0; i < 8; i++)
         add_st(32'h2000 + 32'h100 * i, 32'h2000 + 32'h100 * i, 2'd0, 0, 32'h4004, 0, 4'(i + 1));
      add_ld(32'h2000, 32'h2000, 2'd0, 0, 32'h4004, 0, 4'd8);
      add_st(32'h3000, 32'h3000, 2'd0, 0, 32'h4004, 0, 4'd8);
`ifdef DLK_MONITOR_LRU_EN
      add_ld(32'h2000, 32'h2FFF, 2'd0, 1, 32'h2FFF, 1, 4'd8);
`else
      add_ld(32'h2000, 32'h2FFF, 2'd0, 0, 32'h4004, 0, 4'd8);
`endif

      idle();
      dbg_idx_i = 3'd3;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst.viol",   32'(violation_o), 32'h0);
      chk("rst.vaddr",  violation_addr_o, 32'h0);
      chk("rst.sticky", 32'(sticky_o), 32'h0);
      chk("rst.occ",    32'(occupancy_o), 32'h0);
      chk("rst.dbglim", dbg_limit_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      foreach (vecs[k]) begin
         @(negedge clk_i);
         drive(vecs[k]);
         @(posedge clk_i);
         #1;
         chk($sformatf("v%0d.viol", k),   32'(violation_o), 32'(vecs[k].ev));
         chk($sformatf("v%0d.vaddr", k),  violation_addr_o, vecs[k].eva);
         chk($sformatf("v%0d.sticky", k), 32'(sticky_o), 32'(vecs[k].est));
         chk($sformatf("v%0d.occ", k),    32'(occupancy_o), 32'(vecs[k].eocc));
      end

      @(negedge clk_i);
      idle();
`ifdef DLK_MONITOR_LRU_EN
      chk_dbg(3'd0, 32'h2000, 32'h2001);
      chk_dbg(3'd1, 32'h3000, 32'h3001);
`else
      chk_dbg(3'd0, 32'h3000, 32'h3001);
      chk_dbg(3'd1, 32'h2100, 32'h2101);
      // Pointer advanced past entry 0, so the next victim is entry 1.
      @(negedge clk_i);
      st_valid_i = 1'b1; st_base_i = 32'h3100; st_addr_i = 32'h3100; st_size_i = 2'd0;
      @(negedge clk_i);
      idle();
      chk_dbg(3'd1, 32'h3100, 32'h3101);
      chk_dbg(3'd2, 32'h2200, 32'h2201);
`endif

      // Reset while a violation pulse is showing clears it at once.
      @(negedge clk_i);
      ld_valid_i = 1'b1; ld_base_i = 32'h3000; ld_addr_i = 32'h3005; ld_size_i = 2'd0;
      @(posedge clk_i);
      #1;
      chk("prerst.viol",  32'(violation_o), 32'h1);
      chk("prerst.vaddr", violation_addr_o, 32'h3005);
      rst_ni = 1'b0;
      #1;
      chk("midrst.viol",   32'(violation_o), 32'h0);
      chk("midrst.sticky", 32'(sticky_o), 32'h0);
      chk("midrst.vaddr",  violation_addr_o, 32'h0);
      chk("midrst.occ",    32'(occupancy_o), 32'h0);
      chk_dbg(3'd0, 32'h0, 32'h0);
      idle();
      @(negedge clk_i);
      rst_ni = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
